// File: rtl/ahb_mem_slave.sv
// AHB slave memory with byte-lane writes, programmable wait states
// and a two-cycle ERROR response for illegal accesses.
module ahb_mem_slave #(
  parameter int AW          = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELx,
  input  logic [AW-1:0]         HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int B  = DATA_WIDTH / 8;
  localparam int LB = $clog2(B);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_LOAD =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [LB-1:0]   off_q, off_d;
  logic [2:0]      size_q, size_d;
  logic            write_q, write_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [1:0]      resp_q, resp_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic          accept;
  logic          illegal;
  logic          can_issue;
  logic [AW-1:0] idx_full;
  logic [B-1:0]  be;
  logic          unused_ok;

  assign unused_ok = ^{HTRANS[0], HBURST};
  assign accept    = HSELx & HREADY & HTRANS[1];
  assign can_issue = (state_q == S_IDLE) || (state_q == S_DATA) ||
                     (state_q == S_ERR2);

  always_comb begin
    idx_full = HADDR >> LB;
    illegal  = 1'b0;
    if (idx_full >= AW'(DEPTH)) illegal = 1'b1;
    if (int'(HSIZE) > LB) begin
      illegal = 1'b1;
    end else if ((32'(HADDR[LB-1:0]) &
                 ((32'd1 << HSIZE) - 32'd1)) != 32'd0) begin
      illegal = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else cnt_d = cnt_q - 4'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    // DATA and ERR2 end with HREADY high, so a new beat may start here
    if (can_issue && accept) begin
      idx_d   = idx_full[IW-1:0];
      off_d   = HADDR[LB-1:0];
      size_d  = HSIZE;
      write_d = HWRITE;
      if (illegal) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = S_WAIT;
        cnt_d   = WS_LOAD;
      end else begin
        state_d = S_DATA;
      end
    end
    ready_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    resp_d  = ((state_d == S_ERR1) || (state_d == S_ERR2)) ?
              2'b01 : 2'b00;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      resp_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    be = '0;
    for (int b = 0; b < B; b++) begin
      be[b] = (b >= int'(off_q)) &&
              (b < int'(off_q) + (1 << size_q));
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == S_DATA && write_q) begin
      for (int b = 0; b < B; b++) begin
        if (be[b]) mem_q[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
      end
    end
  end

  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;
  assign HRDATA    = (state_q == S_DATA && !write_q) ?
                     mem_q[idx_q] : '0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Randomized bench for ahb_mem_slave: two instances (0 and 3 wait
// states) checked against a byte-addressed reference memory.
module tb_ahb_mem_slave;

  localparam int DEPTH = 128;
  localparam int NB    = 4 * DEPTH;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  trans;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel0, sel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;

  logic        ro0, ro3;
  logic [1:0]  rs0, rs3;
  logic [31:0] rd0, rd3;

  int n_chk = 0;
  int n_err = 0;

  xfer_t      xq[$];
  logic [7:0] rb [2][NB];

  always #5 clk = ~clk;

  ahb_mem_slave #(.AW(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
                  .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(rst_n), .HSELx(sel0), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HWDATA(hwdata), .HREADY(ro0),
    .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
  );

  ahb_mem_slave #(.AW(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
                  .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESETn(rst_n), .HSELx(sel3), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HWDATA(hwdata), .HREADY(ro3),
    .HREADYOUT(ro3), .HRESP(rs3), .HRDATA(rd3)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NB; i++) rb[d][i] = 8'h00;
  endfunction

  function automatic bit is_bad(xfer_t x);
    return (x.addr >= 32'(NB)) || (x.size > 3'd2) ||
           ((x.addr % (32'd1 << x.size)) != 32'd0);
  endfunction

  function automatic logic [31:0] ref_word(int d, logic [31:0] a);
    int base;
    base = int'(a) & ~3;
    return {rb[d][base+3], rb[d][base+2], rb[d][base+1], rb[d][base]};
  endfunction

  function automatic void ref_write(int d, xfer_t x);
    int a;
    for (int i = 0; i < (1 << x.size); i++) begin
      a = int'(x.addr) + i;
      rb[d][a] = x.wdata[8*(a % 4) +: 8];
    end
  endfunction

  function automatic void push(logic [1:0] t, logic w, logic [2:0] s,
                               logic [31:0] a, logic [31:0] wd);
    xq.push_back('{addr: a, wr: w, size: s, wdata: wd, trans: t});
  endfunction

  task automatic run_seq(input int d);
    xfer_t       dp;
    bit          have_dp;
    bit          bad;
    int          cyc;
    int          budget;
    int          ws;
    logic        r;
    logic [1:0]  rs;
    logic [31:0] rdat;
    logic        exp_r;
    logic [31:0] exp_d;
    have_dp = 0;
    bad     = 0;
    cyc     = 0;
    budget  = 0;
    ws      = (d == 1) ? 3 : 0;
    dp      = '{addr: '0, wr: 1'b0, size: '0, wdata: '0, trans: '0};
    sel0    = (d == 0);
    sel3    = (d == 1);
    while (have_dp || xq.size() > 0) begin
      @(negedge clk);
      r    = (d == 1) ? ro3 : ro0;
      rs   = (d == 1) ? rs3 : rs0;
      rdat = (d == 1) ? rd3 : rd0;
      if (have_dp) begin
        exp_r = bad ? (cyc >= 1) : (cyc >= ws);
        exp_d = (!bad && !dp.wr && exp_r) ?
                ref_word(d, dp.addr) : 32'h0;
        chk("ready", 64'(r), 64'(exp_r));
        chk("resp", 64'(rs), 64'(bad));
        chk("rdata", 64'(rdat), 64'(exp_d));
        cyc++;
      end else begin
        chk("idle_ready", 64'(r), 64'd1);
        chk("idle_resp", 64'(rs), 64'd0);
        chk("idle_rdata", 64'(rdat), 64'd0);
      end
      if (xq.size() > 0) begin
        htrans = xq[0].trans;
        haddr  = xq[0].addr;
        hwrite = xq[0].wr;
        hsize  = xq[0].size;
      end else begin
        htrans = 2'b00;
      end
      hwdata = (have_dp && dp.wr) ? dp.wdata : $urandom;
      if (r) begin
        if (have_dp && !bad && dp.wr) ref_write(d, dp);
        have_dp = 0;
        if (xq.size() > 0) begin
          if (xq[0].trans[1]) begin
            dp      = xq[0];
            have_dp = 1;
            cyc     = 0;
            bad     = is_bad(dp);
          end
          void'(xq.pop_front());
        end
      end
      budget++;
      if (budget > 3000) begin
        chk("timeout", 64'd1, 64'd0);
        xq.delete();
        have_dp = 0;
      end
    end
  endtask

  task automatic gen_random(input int n);
    logic [2:0]  s;
    logic [31:0] a;
    logic [1:0]  t;
    int          k;
    for (int i = 0; i < n; i++) begin
      s = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      a = 32'($urandom_range(0, NB + 31));
      if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << s) - 32'd1);
      k = $urandom_range(0, 9);
      t = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 :
          (k < 6) ? 2'b10 : 2'b11;
      push(t, 1'($urandom_range(0, 1)), s, a, $urandom);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    sel0   = 1'b0;
    sel3   = 1'b0;
    haddr  = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hburst = 3'd0;
    hwdata = '0;
    model_clear();

    #12;
    chk("rst_ready0", 64'(ro0), 64'd1);
    chk("rst_resp0", 64'(rs0), 64'd0);
    chk("rst_rdata0", 64'(rd0), 64'd0);
    chk("rst_ready3", 64'(ro3), 64'd1);
    chk("rst_resp3", 64'(rs3), 64'd0);
    chk("rst_rdata3", 64'(rd3), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    push(2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    push(2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    push(2'b10, 1'b1, 3'd2, 32'h10, 32'h11223344);
    push(2'b10, 1'b1, 3'd0, 32'h11, 32'h0000AB00);
    push(2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    run_seq(0);

    push(2'b10, 1'b0, 3'd2, 32'(NB), 32'h0);
    push(2'b10, 1'b1, 3'd1, 32'h3, 32'hFFFFFFFF);
    push(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    push(2'b10, 1'b0, 3'd2, 32'h0, 32'h0);
    push(2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    run_seq(0);

    push(2'b10, 1'b1, 3'd2, 32'h20, 32'hA0A0A0A0);
    push(2'b11, 1'b1, 3'd2, 32'h24, 32'hB1B1B1B1);
    push(2'b01, 1'b1, 3'd2, 32'h28, 32'hEEEEEEEE);
    push(2'b11, 1'b1, 3'd2, 32'h28, 32'hC2C2C2C2);
    push(2'b11, 1'b1, 3'd2, 32'h2C, 32'hD3D3D3D3);
    for (int i = 0; i < 4; i++)
      push(2'b10, 1'b0, 3'd2, 32'h20 + 32'(4 * i), 32'h0);
    run_seq(0);

    push(2'b10, 1'b1, 3'd2, 32'h40, 32'h12345678);
    push(2'b10, 1'b0, 3'd2, 32'h0, 32'h0);
    push(2'b10, 1'b0, 3'd2, 32'h40, 32'h0);
    push(2'b10, 1'b1, 3'd1, 32'h12, 32'h55AA0000);
    push(2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    push(2'b10, 1'b0, 3'd1, 32'h5, 32'h0);
    push(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    run_seq(1);

    @(negedge clk);
    sel0   = 1'b0;
    sel3   = 1'b1;
    htrans = 2'b10;
    hwrite = 1'b1;
    haddr  = 32'h40;
    hsize  = 3'd2;
    @(negedge clk);
    htrans = 2'b00;
    hwdata = 32'hCAFEF00D;
    chk("wait_ready", 64'(ro3), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(ro3), 64'd1);
    chk("arst_resp", 64'(rs3), 64'd0);
    chk("arst_rdata", 64'(rd3), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    push(2'b10, 1'b0, 3'd2, 32'h40, 32'h0);
    push(2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    run_seq(1);
    push(2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    run_seq(0);

    gen_random(300);
    run_seq(0);
    gen_random(120);
    run_seq(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
- Synthesisable, parametrised AHB slave memory. Replaces the ad-hoc behavioural slave/memory logic inside the master benches.
- Adds:
  - configurable data width and depth
  - HSIZE byte-lane writes
  - programmable wait states
  - two-cycle ERROR response for illegal accesses
  - pipelined address/data phases
- Sits on the shared bus as a target for ahbmaster. Also used standalone in benches with HREADY tied to HREADYOUT.

Parameters:
- AW, 32, address width.
- DATA_WIDTH, 32, data bus width; legal values 32 or 64.
- DEPTH, 128, number of DATA_WIDTH-bit words.
- WAIT_STATES, 0, wait cycles inserted in every OKAY data phase; range 0..15.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset; asynchronous assert, active-low.
- HSELx  in  1  slave select.
- HADDR  in  AW  address.
- HTRANS  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word, 3 = dword.
- HBURST  in  3  ignored; every beat is handled on its own address.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus-wide ready; the previous data phase ends when it is 1.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  2  OKAY=0, ERROR=1; RETRY/SPLIT are never driven.
- HRDATA  out  DATA_WIDTH  read data.

Behaviour:
- Reset (any time, including mid-transfer):
  - state=IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, wait counter=0.
  - All memory words cleared to 0.
  - An in-flight write is discarded.
- Address-phase accept: HSELx & HREADY & HTRANS[1] at a rising edge.
  - Registers address, write flag and size.
  - IDLE/BUSY, or HSELx=0 at that edge: no transfer. Next cycle is a zero-wait OKAY, or IDLE if nothing is pending.
- Byte lanes:
  - B = DATA_WIDTH/8; lane offset = HADDR[log2(B)-1:0].
  - Word index = HADDR >> log2(B).
  - Little-endian.
- Illegal access, decided at accept time:
  - word index >= DEPTH, or
  - (1<<HSIZE) > B, or
  - HADDR not aligned to (1<<HSIZE).
- States:
  - IDLE: HREADYOUT=1, HRESP=OKAY.
    - Legal accept → WAIT if WAIT_STATES>0, else DATA.
    - Illegal accept → ERR1.
  - WAIT: HREADYOUT=0, HRESP=OKAY. Counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0 → DATA.
  - DATA: HREADYOUT=1, HRESP=OKAY. The transfer completes at the next edge.
    - Write: only the enabled lanes of mem[idx] take HWDATA at that edge.
    - Read: HRDATA = mem[idx] (combinational array read) throughout DATA.
    - Next state follows the same rules as IDLE (a new accept may occur at this edge) → WAIT/DATA/ERR1/IDLE.
  - ERR1: HREADYOUT=0, HRESP=ERROR; no memory update → ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR. Next state as from IDLE. A master that issues IDLE here is accepted cleanly.
- HRDATA is 0 in every cycle that is not a read DATA cycle.
- Back-to-back write then read of the same word with WAIT_STATES=0: the read returns the new data. The write commits at the edge that starts the read's data phase.
- Throughput:
  - WAIT_STATES=0: one beat per cycle.
  - Otherwise: WAIT_STATES+1 cycles per beat.
  - Error: 2 cycles.
- HREADYOUT never depends combinationally on inputs.

Test Plan:
- Reset release, WAIT_STATES=0: NONSEQ write addr 0x10 data 0xDEADBEEF, then NONSEQ read 0x10 the next cycle → HREADYOUT stays 1, HRESP=OKAY, HRDATA=0xDEADBEEF in the read data phase.
- Byte write HSIZE=0 to addr 0x11 with HWDATA=0x0000AB00 over stored word 0x11223344 → mem[4]=0x1122AB44; read back returns 0x1122AB44.
- WAIT_STATES=3: read addr 0x0 → HREADYOUT low for exactly 3 cycles, then high 1 cycle with data; a pipelined second address is held until accepted.
- Out-of-range addr 4*DEPTH, and misaligned half-word at 0x3 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged; following IDLE gives OKAY.
- 4-beat INCR write 0x20..0x2C with HSELx held, then HTRANS=BUSY mid-burst → BUSY yields a zero-wait OKAY with no write; all four words correct on read-back.
- Assert HRESETn=0 during WAIT of a write → outputs return to reset values immediately; after release, the target word reads 0.
